// File: rtl/reorder_buffer_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_n_pkg
// Desc     : Shared widths, entry/retire record types and helpers for the ROB.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_n_pkg;

    parameter int ROB_SIZE_BITS = 4;
    parameter int PREG_BITS     = 6;

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 has_dest;
        logic [PREG_BITS-1:0] dest_preg;
        logic [PREG_BITS-1:0] dest_old_preg;
        logic [31:0]          pc;
    } robEntryStruct;

    typedef struct packed {
        logic                 valid;
        logic [PREG_BITS-1:0] dest_preg;
        logic [PREG_BITS-1:0] dest_old_preg;
        logic                 has_dest;
        logic [31:0]          pc;
    } robRetireStruct;

    function automatic int unsigned f_popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_n
// Desc     : Circular in-order-retire reorder buffer, multi-lane dispatch,
//            multi-port completion and multi-lane retire with full flush.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_n #(
    parameter int ROB_SIZE_BITS = reorder_buffer_n_pkg::ROB_SIZE_BITS,
    parameter int DISP_W        = 2,
    parameter int RET_W         = 2,
    parameter int CMPL_W        = 3,
    parameter int PREG_BITS     = reorder_buffer_n_pkg::PREG_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DISP_W-1:0]               disp_valid,
    input  logic [DISP_W*PREG_BITS-1:0]     disp_dest_preg,
    input  logic [DISP_W*PREG_BITS-1:0]     disp_dest_old_preg,
    input  logic [DISP_W-1:0]               disp_has_dest,
    input  logic [DISP_W*32-1:0]            disp_pc,
    output logic                            disp_ready,
    output logic [DISP_W*ROB_SIZE_BITS-1:0] disp_rob_num,
    input  logic [CMPL_W-1:0]               cmpl_valid,
    input  logic [CMPL_W*ROB_SIZE_BITS-1:0] cmpl_rob_num,
    input  logic                            flush,
    output logic [RET_W-1:0]                ret_valid,
    output logic [RET_W*PREG_BITS-1:0]      ret_dest_preg,
    output logic [RET_W*PREG_BITS-1:0]      ret_dest_old_preg,
    output logic [RET_W-1:0]                ret_has_dest,
    output logic [RET_W*32-1:0]             ret_pc,
    output logic [ROB_SIZE_BITS:0]          count,
    output logic                            empty,
    output logic                            full
);
    import reorder_buffer_n_pkg::*;

    localparam int                   C_DEPTH_N = 1 << ROB_SIZE_BITS;
    localparam int                   C_CNT_W   = ROB_SIZE_BITS + 1;
    localparam logic [C_CNT_W-1:0]   C_DEPTH   = C_CNT_W'(C_DEPTH_N);

    logic [C_DEPTH_N-1:0]     valid_q;
    logic [C_DEPTH_N-1:0]     done_q;
    logic [C_DEPTH_N-1:0]     has_dest_q;
    logic [PREG_BITS-1:0]     dest_preg_q     [C_DEPTH_N];
    logic [PREG_BITS-1:0]     dest_old_preg_q [C_DEPTH_N];
    logic [31:0]              pc_q            [C_DEPTH_N];

    logic [ROB_SIZE_BITS-1:0] head_q, head_d;
    logic [ROB_SIZE_BITS-1:0] tail_q, tail_d;
    logic [C_CNT_W-1:0]       count_q, count_d;
    logic [C_CNT_W-1:0]       w_n_disp, w_n_ret;

    // Space check ignores same-cycle retires so accept depends only on state.
    assign disp_ready = (C_DEPTH - count_q) >= C_CNT_W'(DISP_W);
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == C_DEPTH);

    for (genvar i = 0; i < DISP_W; i++) begin : g_disp_tag
        assign disp_rob_num[i*ROB_SIZE_BITS +: ROB_SIZE_BITS] = tail_q + ROB_SIZE_BITS'(i);
    end

    for (genvar j = 0; j < RET_W; j++) begin : g_ret
        logic [ROB_SIZE_BITS-1:0] w_idx;
        logic                     w_ok;

        assign w_idx = head_q + ROB_SIZE_BITS'(j);

        // Lane j retires only if every entry from head through head+j is done.
        always_comb begin
            w_ok = count_q > C_CNT_W'(j);
            for (int k = 0; k <= j; k++) begin
                w_ok = w_ok & valid_q[head_q + ROB_SIZE_BITS'(k)]
                            & done_q[head_q + ROB_SIZE_BITS'(k)];
            end
        end

        assign ret_valid[j] = w_ok & ~flush;
        assign ret_dest_preg[j*PREG_BITS +: PREG_BITS]     = ret_valid[j] ? dest_preg_q[w_idx]     : '0;
        assign ret_dest_old_preg[j*PREG_BITS +: PREG_BITS] = ret_valid[j] ? dest_old_preg_q[w_idx] : '0;
        assign ret_has_dest[j]                             = ret_valid[j] & has_dest_q[w_idx];
        assign ret_pc[j*32 +: 32]                          = ret_valid[j] ? pc_q[w_idx]            : '0;
    end

    always_comb begin
        w_n_ret  = C_CNT_W'(f_popcount(32'(ret_valid)));
        w_n_disp = disp_ready ? C_CNT_W'(f_popcount(32'(disp_valid))) : '0;
        head_d   = head_q + ROB_SIZE_BITS'(w_n_ret);
        tail_d   = tail_q + ROB_SIZE_BITS'(w_n_disp);
        count_d  = count_q + w_n_disp - w_n_ret;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int p = 0; p < CMPL_W; p++) begin
                if (cmpl_valid[p] && valid_q[cmpl_rob_num[p*ROB_SIZE_BITS +: ROB_SIZE_BITS]]) begin
                    done_q[cmpl_rob_num[p*ROB_SIZE_BITS +: ROB_SIZE_BITS]] <= 1'b1;
                end
            end
            for (int j = 0; j < RET_W; j++) begin
                if (ret_valid[j]) begin
                    valid_q[head_q + ROB_SIZE_BITS'(j)] <= 1'b0;
                    done_q[head_q + ROB_SIZE_BITS'(j)]  <= 1'b0;
                end
            end
            // Slots tail..tail+DISP_W-1 are free whenever disp_ready is high.
            if (disp_ready) begin
                for (int i = 0; i < DISP_W; i++) begin
                    if (disp_valid[i]) begin
                        valid_q[tail_q + ROB_SIZE_BITS'(i)]         <= 1'b1;
                        done_q[tail_q + ROB_SIZE_BITS'(i)]          <= 1'b0;
                        has_dest_q[tail_q + ROB_SIZE_BITS'(i)]      <= disp_has_dest[i];
                        dest_preg_q[tail_q + ROB_SIZE_BITS'(i)]     <= disp_dest_preg[i*PREG_BITS +: PREG_BITS];
                        dest_old_preg_q[tail_q + ROB_SIZE_BITS'(i)] <= disp_dest_old_preg[i*PREG_BITS +: PREG_BITS];
                        pc_q[tail_q + ROB_SIZE_BITS'(i)]            <= disp_pc[i*32 +: 32];
                    end
                end
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_n
// Desc     : Self-checking bench for reorder_buffer_n: directed table, corner
//            sequences and random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer_n;
    import reorder_buffer_n_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  disp_valid;
    logic [11:0] disp_dest_preg;
    logic [11:0] disp_dest_old_preg;
    logic [1:0]  disp_has_dest;
    logic [63:0] disp_pc;
    logic        disp_ready;
    logic [7:0]  disp_rob_num;
    logic [2:0]  cmpl_valid;
    logic [11:0] cmpl_rob_num;
    logic        flush;
    logic [1:0]  ret_valid;
    logic [11:0] ret_dest_preg;
    logic [11:0] ret_dest_old_preg;
    logic [1:0]  ret_has_dest;
    logic [63:0] ret_pc;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    reorder_buffer_n dut (
        .clk                (clk),
        .reset              (reset),
        .disp_valid         (disp_valid),
        .disp_dest_preg     (disp_dest_preg),
        .disp_dest_old_preg (disp_dest_old_preg),
        .disp_has_dest      (disp_has_dest),
        .disp_pc            (disp_pc),
        .disp_ready         (disp_ready),
        .disp_rob_num       (disp_rob_num),
        .cmpl_valid         (cmpl_valid),
        .cmpl_rob_num       (cmpl_rob_num),
        .flush              (flush),
        .ret_valid          (ret_valid),
        .ret_dest_preg      (ret_dest_preg),
        .ret_dest_old_preg  (ret_dest_old_preg),
        .ret_has_dest       (ret_has_dest),
        .ret_pc             (ret_pc),
        .count              (count),
        .empty              (empty),
        .full               (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pay_n = 0;

    // Reference model: program-order queue of in-flight instructions.
    typedef struct {
        int          tag;
        bit          done;
        logic [5:0]  preg;
        logic [5:0]  old;
        logic        hd;
        logic [31:0] pc;
    } ment_t;
    ment_t mq[$];
    int    m_tail = 0;

    typedef struct {
        logic [1:0]  dv;
        logic [2:0]  cv;
        logic [11:0] ctag;
        logic [1:0]  e_ret;
        logic [4:0]  e_cnt;
        logic [7:0]  e_rob;
        logic [11:0] e_old;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_nret();
        int n;
        n = 0;
        if (flush) return 0;
        for (int j = 0; j < 2; j++) begin
            if (j < mq.size() && mq[j].done) n++;
            else break;
        end
        return n;
    endfunction

    task automatic set_in(input logic [1:0] dv, input logic [2:0] cv,
                          input logic [11:0] ctag, input logic fl);
        int n;
        disp_valid   = dv;
        cmpl_valid   = cv;
        cmpl_rob_num = ctag;
        flush        = fl;
        for (int i = 0; i < 2; i++) begin
            n = pay_n + i;
            disp_pc[i*32 +: 32]           = 32'h100 + 32'(4 * n);
            disp_dest_preg[i*6 +: 6]      = 6'(33 + n);
            disp_dest_old_preg[i*6 +: 6]  = 6'(1 + n);
            disp_has_dest[i]              = (n % 3) != 2;
        end
        pay_n += 2;
    endtask

    task automatic model_check();
        int          nr;
        logic [1:0]  e_v, e_hd;
        logic [11:0] e_p, e_o;
        logic [63:0] e_pc;
        nr = m_nret();
        e_v = '0; e_hd = '0; e_p = '0; e_o = '0; e_pc = '0;
        for (int j = 0; j < 2; j++) begin
            if (j < nr) begin
                e_v[j]          = 1'b1;
                e_hd[j]         = mq[j].hd;
                e_p[j*6 +: 6]   = mq[j].preg;
                e_o[j*6 +: 6]   = mq[j].old;
                e_pc[j*32 +: 32] = mq[j].pc;
            end
        end
        chk("disp_ready", 64'(disp_ready), 64'((DEPTH - mq.size()) >= 2));
        chk("disp_rob_num", 64'(disp_rob_num), 64'({4'((m_tail + 1) % DEPTH), 4'(m_tail % DEPTH)}));
        chk("count", 64'(count), 64'(mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("ret_valid", 64'(ret_valid), 64'(e_v));
        chk("ret_dest_preg", 64'(ret_dest_preg), 64'(e_p));
        chk("ret_dest_old_preg", 64'(ret_dest_old_preg), 64'(e_o));
        chk("ret_has_dest", 64'(ret_has_dest), 64'(e_hd));
        chk("ret_pc", ret_pc, e_pc);
    endtask

    task automatic tick();
        int    nr;
        bit    rdy;
        ment_t e;
        nr  = m_nret();
        rdy = (DEPTH - mq.size()) >= 2;
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            repeat (nr) void'(mq.pop_front());
            for (int p = 0; p < 3; p++) begin
                if (cmpl_valid[p]) begin
                    foreach (mq[k]) begin
                        if (mq[k].tag == int'(cmpl_rob_num[p*4 +: 4])) mq[k].done = 1'b1;
                    end
                end
            end
            if (rdy) begin
                for (int i = 0; i < 2; i++) begin
                    if (disp_valid[i]) begin
                        e.tag  = m_tail;
                        e.done = 1'b0;
                        e.preg = disp_dest_preg[i*6 +: 6];
                        e.old  = disp_dest_old_preg[i*6 +: 6];
                        e.hd   = disp_has_dest[i];
                        e.pc   = disp_pc[i*32 +: 32];
                        mq.push_back(e);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic settle();
        #2;
        if (!reset) model_check();
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(2'b00, 3'b000, 12'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        pay_n = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ct;
        logic [2:0]  cv;
        logic [1:0]  dv;
        int          sel;

        tbl[0] = '{2'b11, 3'b000, 12'h000, 2'b00, 5'd0, 8'h10, 12'h000};
        tbl[1] = '{2'b00, 3'b001, 12'h001, 2'b00, 5'd2, 8'h32, 12'h000};
        tbl[2] = '{2'b00, 3'b001, 12'h000, 2'b00, 5'd2, 8'h32, 12'h000};
        tbl[3] = '{2'b00, 3'b000, 12'h000, 2'b11, 5'd2, 8'h32, {6'd2, 6'd1}};
        tbl[4] = '{2'b00, 3'b000, 12'h000, 2'b00, 5'd0, 8'h32, 12'h000};

        // Reset state, then dispatch pair and out-of-order completion.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(tbl[i].dv, tbl[i].cv, tbl[i].ctag, 1'b0);
            settle();
            chk("tbl_ret_valid", 64'(ret_valid), 64'(tbl[i].e_ret));
            chk("tbl_count", 64'(count), 64'(tbl[i].e_cnt));
            chk("tbl_rob_num", 64'(disp_rob_num), 64'(tbl[i].e_rob));
            chk("tbl_ret_old", 64'(ret_dest_old_preg), 64'(tbl[i].e_old));
            tick();
        end
        settle();
        chk("drain_empty", 64'(empty), 64'd1);
        tick();

        // Fill to full, blocked dispatch, non-consecutive completion.
        do_reset();
        repeat (8) begin
            set_in(2'b11, 3'b000, 12'h0, 1'b0);
            cycle();
        end
        set_in(2'b11, 3'b000, 12'h0, 1'b0);
        settle();
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_count", 64'(count), 64'd16);
        tick();
        set_in(2'b00, 3'b011, {4'd0, 4'd2, 4'd0}, 1'b0);
        settle();
        chk("blocked_count", 64'(count), 64'd16);
        tick();
        set_in(2'b00, 3'b000, 12'h0, 1'b0);
        settle();
        chk("partial_ret", 64'(ret_valid), 64'b01);
        tick();
        settle();
        chk("partial_count", 64'(count), 64'd15);
        tick();

        // Wrap-around: retire down to tags 14,15 then reuse tags 0..3.
        for (int t = 1; t <= 13; t += 3) begin
            ct = {4'(t + 2), 4'(t + 1), 4'(t)};
            cv = (t + 2 <= 13) ? 3'b111 : (t + 1 <= 13) ? 3'b011 : 3'b001;
            set_in(2'b00, cv, ct, 1'b0);
            cycle();
        end
        repeat (8) begin
            set_in(2'b00, 3'b000, 12'h0, 1'b0);
            cycle();
        end
        settle();
        chk("wrap_count", 64'(count), 64'd2);
        set_in(2'b11, 3'b000, 12'h0, 1'b0);
        settle();
        chk("wrap_tags", 64'(disp_rob_num), 64'h10);
        tick();
        set_in(2'b11, 3'b000, 12'h0, 1'b0);
        cycle();
        set_in(2'b00, 3'b111, {4'd0, 4'd15, 4'd14}, 1'b0);
        cycle();
        set_in(2'b00, 3'b111, {4'd3, 4'd2, 4'd1}, 1'b0);
        settle();
        chk("wrap_ret_a", 64'(ret_valid), 64'b11);
        tick();
        set_in(2'b00, 3'b000, 12'h0, 1'b0);
        settle();
        chk("wrap_ret_b", 64'(ret_valid), 64'b11);
        tick();
        cycle();
        cycle();

        // Completion on all ports concurrent with dispatch, head at 3.
        do_reset();
        repeat (3) begin
            set_in(2'b11, 3'b000, 12'h0, 1'b0);
            cycle();
        end
        set_in(2'b00, 3'b111, {4'd2, 4'd1, 4'd0}, 1'b0);
        cycle();
        set_in(2'b00, 3'b000, 12'h0, 1'b0);
        cycle();
        settle();
        chk("head3_ret", 64'(ret_valid), 64'b01);
        tick();
        set_in(2'b11, 3'b111, {4'd5, 4'd4, 4'd3}, 1'b0);
        settle();
        chk("simul_tags", 64'(disp_rob_num), 64'h76);
        tick();
        set_in(2'b00, 3'b000, 12'h0, 1'b0);
        settle();
        chk("simul_ret_a", 64'(ret_valid), 64'b11);
        chk("simul_cnt_a", 64'(count), 64'd5);
        tick();
        settle();
        chk("simul_ret_b", 64'(ret_valid), 64'b01);
        chk("simul_cnt_b", 64'(count), 64'd3);
        tick();
        settle();
        chk("simul_cnt_c", 64'(count), 64'd2);
        tick();

        // Flush with ready-to-retire entries, completions and dispatch.
        do_reset();
        repeat (5) begin
            set_in(2'b11, 3'b000, 12'h0, 1'b0);
            cycle();
        end
        set_in(2'b00, 3'b011, {4'd0, 4'd1, 4'd0}, 1'b0);
        cycle();
        set_in(2'b11, 3'b111, {4'd4, 4'd3, 4'd2}, 1'b1);
        settle();
        chk("flush_ret_gated", 64'(ret_valid), 64'b00);
        chk("flush_pre_count", 64'(count), 64'd10);
        tick();
        set_in(2'b11, 3'b000, 12'h0, 1'b0);
        settle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ret", 64'(ret_valid), 64'b00);
        chk("flush_tags", 64'(disp_rob_num), 64'h10);
        tick();
        cycle();

        // Random traffic against the model, alternating fill/drain bias.
        do_reset();
        for (int it = 0; it < 800; it++) begin
            sel = $urandom_range(0, 9);
            if ((it / 100) % 2 == 0) dv = (sel < 7) ? 2'b11 : (sel < 9) ? 2'b01 : 2'b00;
            else                     dv = (sel < 2) ? 2'b11 : (sel < 4) ? 2'b01 : 2'b00;
            for (int p = 0; p < 3; p++) begin
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    ct[p*4 +: 4] = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    ct[p*4 +: 4] = 4'($urandom);
            end
            cv = 3'($urandom);
            set_in(dv, cv, ct, $urandom_range(0, 59) == 0);
            disp_pc            = {$urandom, $urandom};
            disp_dest_preg     = 12'($urandom);
            disp_dest_old_preg = 12'($urandom);
            disp_has_dest      = 2'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
